// File: rtl/l2_pmem_burst_adaptor.sv
// Splits one L2 line read/write into BEATS burst transfers to main memory and
// returns a single-cycle line-level completion to the L2 controller.
module l2_pmem_burst_adaptor #(
   parameter int unsigned LINE_WIDTH  = 256,
   parameter int unsigned BURST_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_WIDTH-1:0]  address_i,
   input  logic [LINE_WIDTH-1:0]  line_i,
   input  logic                   read_i,
   input  logic                   write_i,
   output logic [LINE_WIDTH-1:0]  line_o,
   output logic                   resp_o,
   output logic [ADDR_WIDTH-1:0]  address_o,
   output logic [BURST_WIDTH-1:0] burst_o,
   input  logic [BURST_WIDTH-1:0] burst_i,
   output logic                   read_o,
   output logic                   write_o,
   input  logic                   resp_i
);

   localparam int unsigned BEATS = LINE_WIDTH / BURST_WIDTH;
   localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned OFFS  = $clog2(LINE_WIDTH / 8);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFS;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      DONE
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [CW-1:0]           count;
   logic                    last_beat;
   logic [LINE_WIDTH-1:0]   rd_line;
   logic [LINE_WIDTH-1:0]   wr_line;
   logic [ADDR_WIDTH-1:0]   addr_buf;

   assign last_beat = resp_i && (count == CW'(BEATS - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a simultaneous read/write request is taken as a write
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (write_i) begin
               state_next = WRITE;
            end else if (read_i) begin
               state_next = READ;
            end
         end
         READ: begin
            if (last_beat) begin
               state_next = DONE;
            end
         end
         WRITE: begin
            if (last_beat) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      read_o    = 1'b0;
      write_o   = 1'b0;
      resp_o    = 1'b0;
      burst_o   = '0;
      unique case (state)
         READ: begin
            read_o = 1'b1;
         end
         WRITE: begin
            write_o = 1'b1;
            for (int unsigned b = 0; b < BEATS; b++) begin
               if (count == CW'(b)) begin
                  burst_o = wr_line[b*BURST_WIDTH +: BURST_WIDTH];
               end
            end
         end
         DONE: begin
            resp_o = 1'b1;
         end
         default: begin
            resp_o = 1'b0;
         end
      endcase
   end

   assign address_o = addr_buf;
   // Read line has its own buffer so a write-back never disturbs line_o
   assign line_o    = rd_line;

   // Datapath: request latching, beat capture and beat counting
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         rd_line  <= '0;
         wr_line  <= '0;
         addr_buf <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (write_i) begin
                  wr_line  <= line_i;
                  addr_buf <= address_i & ALIGN_MASK;
                  count    <= '0;
               end else if (read_i) begin
                  addr_buf <= address_i & ALIGN_MASK;
                  count    <= '0;
               end
            end
            READ: begin
               if (resp_i) begin
                  for (int unsigned b = 0; b < BEATS; b++) begin
                     if (count == CW'(b)) begin
                        rd_line[b*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                     end
                  end
                  count <= last_beat ? '0 : count + 1'b1;
               end
            end
            WRITE: begin
               if (resp_i) begin
                  count <= last_beat ? '0 : count + 1'b1;
               end
            end
            default: begin
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l2_pmem_burst_adaptor.sv
// Scoreboard bench: the driver acts as L2 and as burst memory, pushing expected
// line responses and write beats; a negedge monitor pops and compares them.
module tb_l2_pmem_burst_adaptor;

   localparam int LW = 256;
   localparam int BW = 64;
   localparam int AW = 32;
   localparam int NB = LW / BW;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] address_i;
   logic [LW-1:0] line_i;
   logic          read_i;
   logic          write_i;
   logic [LW-1:0] line_o;
   logic          resp_o;
   logic [AW-1:0] address_o;
   logic [BW-1:0] burst_o;
   logic [BW-1:0] burst_i;
   logic          read_o;
   logic          write_o;
   logic          resp_i;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] line;
   } exp_t;

   exp_t          sb_q[$];
   logic [BW-1:0] beat_q[$];
   bit            pattern_q[$];
   int            checks = 0;
   int            passed = 0;

   l2_pmem_burst_adaptor #(
      .LINE_WIDTH (LW),
      .BURST_WIDTH(BW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .address_i(address_i),
      .line_i   (line_i),
      .read_i   (read_i),
      .write_i  (write_i),
      .line_o   (line_o),
      .resp_o   (resp_o),
      .address_o(address_o),
      .burst_o  (burst_o),
      .burst_i  (burst_i),
      .read_o   (read_o),
      .write_o  (write_o),
      .resp_i   (resp_i)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [LW-1:0] act,
                                 input logic [LW-1:0] exp);
      checks++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] l;
      for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // Monitor: compares whatever the DUT presents against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (write_o && resp_i) begin
            if (beat_q.size() == 0) begin
               check("unexpected_wr_beat", 1, 0);
            end else begin
               check("wr_beat", burst_o, beat_q.pop_front());
            end
         end
         if ((read_o || write_o) && sb_q.size() != 0) begin
            check("addr_active", address_o, sb_q[0].addr);
            check("op_kind", {write_o, read_o}, sb_q[0].wr ? 2'b10 : 2'b01);
         end
         if (resp_o) begin
            if (sb_q.size() == 0) begin
               check("unexpected_resp", 1, 0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("addr_resp", address_o, e.addr);
               check("req_low_in_done", {read_o, write_o}, 2'b00);
               if (!e.wr) check("rd_line", line_o, e.line);
            end
         end
      end
   end

   // One line transaction; memory side stalls from pattern_q or at random
   task automatic run_txn(input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [LW-1:0] line, input int stall_pct, input bit keep);
      exp_t e;
      int   beats = 0;
      int   guard = 0;
      bit   give;
      e.wr   = wr;
      e.addr = addr & 32'hFFFF_FFE0;
      e.line = line;
      sb_q.push_back(e);
      if (wr) for (int k = 0; k < NB; k++) beat_q.push_back(line[k*BW +: BW]);
      resp_i    = 1'b0;
      read_i    = rd;
      write_i   = wr;
      address_i = addr;
      line_i    = wr ? line : rand_line();
      while (!(read_o || write_o) && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 20) begin
         check("start_timeout", 0, 1);
         sb_q.delete();
         beat_q.delete();
         read_i  = 1'b0;
         write_i = 1'b0;
         return;
      end
      guard = 0;
      while (beats < NB && guard < 200) begin
         check("still_active", {write_o, read_o}, wr ? 2'b10 : 2'b01);
         give    = (pattern_q.size() != 0) ? pattern_q.pop_front()
                                           : ($urandom_range(99) >= stall_pct);
         resp_i  = give;
         burst_i = (give && !wr) ? line[beats*BW +: BW] : {$urandom, $urandom};
         @(posedge clk); #1;
         guard++;
         if (give) beats++;
      end
      if (guard >= 200) check("beat_timeout", 0, 1);
      check("resp_after_last_beat", resp_o, 1);
      // Stray memory handshakes in DONE must be ignored
      resp_i  = $urandom_range(1);
      burst_i = {$urandom, $urandom};
      if (!keep) begin
         read_i  = 1'b0;
         write_i = 1'b0;
      end
      @(posedge clk); #1;
      check("turnaround_idle", {resp_o, read_o, write_o}, 3'b000);
      resp_i = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_read_o"}, read_o, 0);
      check({tag, "_write_o"}, write_o, 0);
      check({tag, "_resp_o"}, resp_o, 0);
      check({tag, "_address_o"}, address_o, 0);
      check({tag, "_burst_o"}, burst_o, 0);
      check({tag, "_line_o"}, line_o, 0);
   endtask

   initial begin
      logic [LW-1:0] l;
      int            guard;
      rst       = 1'b1;
      address_i = '0;
      line_i    = '0;
      read_i    = 1'b0;
      write_i   = 1'b0;
      burst_i   = '0;
      resp_i    = 1'b0;
      #3;
      check_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Read, no stalls
      l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
      run_txn(1, 0, 32'h0000_1234, l, 0, 0);
      check("addr_aligned_1234", address_o, 32'h0000_1220);
      check("line_held_idle", line_o, l);

      // Read with stall pattern 1,0,0,1,1,0,1
      pattern_q = '{1, 0, 0, 1, 1, 0, 1};
      run_txn(1, 0, 32'h0000_4FFF, rand_line(), 0, 0);

      // Write, resp_i held high
      l = {64'hD3D3_3333_0000_0003, 64'hD2D2_2222_0000_0002,
           64'hD1D1_1111_0000_0001, 64'hD0D0_0000_0000_0000};
      run_txn(0, 1, 32'h8000_00E0, l, 0, 0);

      // Simultaneous read and write behaves as a write
      run_txn(1, 1, 32'h0000_2040, rand_line(), 30, 0);

      // Read held through DONE: second read only after returning to IDLE
      run_txn(1, 0, 32'h0000_0100, rand_line(), 20, 1);
      run_txn(1, 0, 32'h0000_0100, rand_line(), 20, 0);

      // Reset during READ after two beats
      read_i    = 1'b1;
      address_i = 32'h0000_7777;
      guard     = 0;
      while (!read_o && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      check("abort_read_started", read_o, 1);
      for (int k = 0; k < 2; k++) begin
         resp_i  = 1'b1;
         burst_i = {$urandom, $urandom} | 64'h1;
         @(posedge clk); #1;
      end
      resp_i = 1'b0;
      read_i = 1'b0;
      check("abort_still_reading", read_o, 1);
      #2 rst = 1'b1;
      #1;
      check_all_zero("mid_reset");
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("no_resp_after_abort", resp_o, 0);
      run_txn(1, 0, 32'h0000_9000, rand_line(), 25, 0);

      // Randomised mix
      for (int n = 0; n < 40; n++) begin
         bit w;
         w = $urandom_range(1);
         run_txn(!w || ($urandom_range(3) == 0), w, $urandom, rand_line(),
                 $urandom_range(60), 0);
      end

      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_drained", sb_q.size(), 0);
      check("beats_drained", beat_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got %0d expected %0d", passed, checks);
      $fatal(1, "timeout");
   end

endmodule
